gpu_pixel_arbiter: RTL and testbench

- Parametrised successor to the fixed two-engine line/fill output select.
- Merges pixel streams from NUM_ENG raster engines (line, fill, future circle/quad) into one registered output stream, using valid/ready handshakes throughout.
- Arbitration is round-robin, locked per primitive: once an engine is granted, it keeps the grant until it has transferred its last pixel.
- Buffers accepted pixels in a small output FIFO so downstream backpressure (memory controller) does not stall arbitration.

---
 rtl/gpu_pkg.sv | 48 ++++
 rtl/gpu_pixel_arbiter_if.sv | 40 ++++
 rtl/gpu_pixel_fifo.sv | 55 +++++
 rtl/gpu_pixel_arbiter.sv | 148 ++++++++++++++
 tb/tb_gpu_pixel_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the pixel arbiter: FSM states, pixel record, round-robin pick.
// Pixel field widths follow the gpu_definitions screen geometry (10-bit x, 9-bit y, 8-bit channels).
// ENG_ID_BITS covers the largest supported engine count (8).
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;
  localparam int MAX_ENG      = 8;
  localparam int ENG_ID_BITS  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]   x;
    logic [HEIGHT_BITS-1:0]  y;
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
    logic [ENG_ID_BITS-1:0]  eng_id;
  } pixel_t;

  // First requester searching upward from last+1, wrapping modulo n.
  // Returns 0 when nothing requests (callers only use it when some request is up).
  function automatic logic [ENG_ID_BITS-1:0] rr_pick(
    input logic [MAX_ENG-1:0]     req,
    input logic [ENG_ID_BITS-1:0] last,
    input int                     n
  );
    logic [ENG_ID_BITS-1:0] pick;
    logic                   found;
    int                     idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_ENG; k++) begin
      idx = (int'(last) + k) % n;
      if ((k <= n) && !found && req[idx]) begin
        pick  = ENG_ID_BITS'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gpu_pixel_arbiter_if.sv
// Bundle of the engine-side and memory-side pixel handshakes of the arbiter.
// Pure wiring, no latency.
// master drives engine valids/data and downstream ready; slave is the arbiter.
interface gpu_pixel_arbiter_if #(
  parameter int NUM_ENG      = 4,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8
);
  localparam int ID_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic [NUM_ENG-1:0]                eng_valid_i;
  logic [NUM_ENG-1:0]                eng_last_i;
  logic [NUM_ENG*WIDTH_BITS-1:0]     eng_x_i;
  logic [NUM_ENG*HEIGHT_BITS-1:0]    eng_y_i;
  logic [NUM_ENG*3*CHANNEL_BITS-1:0] eng_rgb_i;
  logic [NUM_ENG-1:0]                eng_ready_o;

  logic                    pix_valid_o;
  logic                    pix_ready_i;
  logic [WIDTH_BITS-1:0]   x_o;
  logic [HEIGHT_BITS-1:0]  y_o;
  logic [CHANNEL_BITS-1:0] r_o;
  logic [CHANNEL_BITS-1:0] g_o;
  logic [CHANNEL_BITS-1:0] b_o;
  logic [ID_W-1:0]         eng_id_o;
  logic                    busy_o;
  logic [15:0]             drop_cnt_o;

  modport master (
    output eng_valid_i, eng_last_i, eng_x_i, eng_y_i, eng_rgb_i, pix_ready_i,
    input  eng_ready_o, pix_valid_o, x_o, y_o, r_o, g_o, b_o, eng_id_o, busy_o, drop_cnt_o
  );

  modport slave (
    input  eng_valid_i, eng_last_i, eng_x_i, eng_y_i, eng_rgb_i, pix_ready_i,
    output eng_ready_o, pix_valid_o, x_o, y_o, r_o, g_o, b_o, eng_id_o, busy_o, drop_cnt_o
  );

endinterface

// File: rtl/gpu_pixel_fifo.sv
// Synchronous FIFO of pixel records; head entry is always presented on dout.
// Latency: a pushed entry is visible on dout the cycle after the push at the earliest.
// Push while full is ignored unless a pop happens the same cycle; head holds while not popped.
module gpu_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  pixel_t                     din,
  input  logic                       pop,
  output pixel_t                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pixel_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, power-of-two pointers wrap naturally, occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin merge of NUM_ENG raster pixel streams, grant locked until the primitive's last pixel.
// Latency: 1 idle cycle to arbitrate; accepted pixel reaches the output one cycle after accept.
// Engines stall via ready when the output FIFO is full; GPU_PIXEL_ARBITER_PIXEL_CLIP_EN drops off-screen pixels.
module gpu_pixel_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_ENG      = 4,
  parameter int WIDTH_BITS   = gpu_pkg::WIDTH_BITS,
  parameter int HEIGHT_BITS  = gpu_pkg::HEIGHT_BITS,
  parameter int CHANNEL_BITS = gpu_pkg::CHANNEL_BITS,
  parameter int FIFO_DEPTH   = 4
`ifdef GPU_PIXEL_ARBITER_PIXEL_CLIP_EN
  ,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480
`endif
) (
  input logic                clk,
  input logic                n_rst,
  gpu_pixel_arbiter_if.slave bus
);
  localparam int ID_W     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int RGB_BITS = 3 * CHANNEL_BITS;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

  arb_state_t             state_q, state_d;
  logic [ENG_ID_BITS-1:0] grant_q, grant_d;
  logic [ENG_ID_BITS-1:0] last_q, last_d;
  logic [NUM_ENG-1:0]     ready;
  logic                   xfer;
  logic                   clip;

  logic                   sel_valid;
  logic                   sel_last;
  logic [WIDTH_BITS-1:0]  sel_x;
  logic [HEIGHT_BITS-1:0] sel_y;
  logic [RGB_BITS-1:0]    sel_rgb;

  pixel_t                 push_pix;
  pixel_t                 head;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       count;

  // Slices of the currently granted engine.
  assign sel_valid = bus.eng_valid_i[grant_q];
  assign sel_last  = bus.eng_last_i[grant_q];
  assign sel_x     = bus.eng_x_i[int'(grant_q)*WIDTH_BITS +: WIDTH_BITS];
  assign sel_y     = bus.eng_y_i[int'(grant_q)*HEIGHT_BITS +: HEIGHT_BITS];
  assign sel_rgb   = bus.eng_rgb_i[int'(grant_q)*RGB_BITS +: RGB_BITS];

`ifdef GPU_PIXEL_ARBITER_PIXEL_CLIP_EN
  logic [15:0] drop_q;

  assign clip = (int'(sel_x) >= SCREEN_W) || (int'(sel_y) >= SCREEN_H);

  // Count clipped pixels that were handshaken, saturating.
  always_ff @(posedge clk) begin
    if (n_rst)                                   drop_q <= '0;
    else if (xfer && clip && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
  end

  assign bus.drop_cnt_o = drop_q;
`else
  assign clip           = 1'b0;
  assign bus.drop_cnt_o = '0;
`endif

  assign pop = !empty && bus.pix_ready_i;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ENG_ID_BITS'(NUM_ENG - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Arbitrate in IDLE; in LOCK accept from the granted engine until its last pixel.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ready   = '0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.eng_valid_i) begin
          grant_d = rr_pick(MAX_ENG'(bus.eng_valid_i), last_q, NUM_ENG);
          state_d = LOCK;
        end
      end
      LOCK: begin
        // Clipped pixels never occupy the FIFO, so they are taken even when it is full.
        ready[grant_q] = clip || !full || pop;
        xfer           = sel_valid && (clip || !full || pop);
        if (xfer && sel_last) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = xfer && !clip;

  assign push_pix = '{
    x:      sel_x,
    y:      sel_y,
    r:      sel_rgb[RGB_BITS-1 -: CHANNEL_BITS],
    g:      sel_rgb[2*CHANNEL_BITS-1 -: CHANNEL_BITS],
    b:      sel_rgb[CHANNEL_BITS-1:0],
    eng_id: grant_q
  };

  gpu_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (n_rst),
    .push  (push),
    .din   (push_pix),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.eng_ready_o = ready;
  assign bus.pix_valid_o = !empty;
  assign bus.x_o         = head.x;
  assign bus.y_o         = head.y;
  assign bus.r_o         = head.r;
  assign bus.g_o         = head.g;
  assign bus.b_o         = head.b;
  assign bus.eng_id_o    = ID_W'(head.eng_id);
  assign bus.busy_o      = (state_q == LOCK) || (count != '0);

endmodule

// File: tb/tb_gpu_pixel_arbiter.sv
// Bench for gpu_pixel_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// Engine drivers advance on the model's prediction of the handshake, never on the DUT's ready.
module tb_gpu_pixel_arbiter;
  localparam int NE    = 4;
  localparam int WB    = 10;
  localparam int HB    = 9;
  localparam int CB    = 8;
  localparam int DEPTH = 4;
  localparam int SW    = 640;
  localparam int SH    = 480;
`ifdef GPU_PIXEL_ARBITER_PIXEL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  gpu_pixel_arbiter_if #(.NUM_ENG(NE), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) bus ();

  gpu_pixel_arbiter #(
    .NUM_ENG(NE), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB), .FIFO_DEPTH(DEPTH)
`ifdef GPU_PIXEL_ARBITER_PIXEL_CLIP_EN
    , .SCREEN_W(SW), .SCREEN_H(SH)
`endif
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  typedef struct { int x; int y; int rgb; int id; } exp_t;

  exp_t m_q[$];
  int   src_x   [NE][64];
  int   src_y   [NE][64];
  int   src_rgb [NE][64];
  bit   src_last[NE][64];
  int   src_len [NE];
  int   src_pos [NE];

  bit   m_lock;
  int   m_grant, m_last, m_drop, m_accepted;
  int   valid_pct, rdy_pct;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit off_screen(input int x, input int y);
    return CLIP_EN && ((x >= SW) || (y >= SH));
  endfunction

  function automatic bit pending();
    bit p = 1'b0;
    for (int e = 0; e < NE; e++) if (src_pos[e] < src_len[e]) p = 1'b1;
    return p;
  endfunction

  task automatic clear_src();
    for (int e = 0; e < NE; e++) begin
      src_len[e] = 0;
      src_pos[e] = 0;
    end
  endtask

  task automatic add_pix(input int e, input int x, input int y, input int rgb, input bit last);
    src_x[e][src_len[e]]    = x;
    src_y[e][src_len[e]]    = y;
    src_rgb[e][src_len[e]]  = rgb;
    src_last[e][src_len[e]] = last;
    src_len[e]++;
  endtask

  task automatic add_rand_prim(input int e);
    int n = int'($urandom_range(1, 4));
    for (int i = 0; i < n; i++)
      add_pix(e, int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 24'hFFFFFF)), i == n - 1);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lock = 1'b0;
    m_grant = 0;
    m_last = NE - 1;
    m_drop = 0;
  endtask

  task automatic drive();
    for (int e = 0; e < NE; e++) begin
      bit has = src_pos[e] < src_len[e];
      int p   = has ? src_pos[e] : 0;
      bus.eng_valid_i[e]           = has && ($urandom_range(99) < valid_pct);
      bus.eng_last_i[e]            = has && src_last[e][p];
      bus.eng_x_i[e*WB +: WB]      = has ? WB'(src_x[e][p]) : '0;
      bus.eng_y_i[e*HB +: HB]      = has ? HB'(src_y[e][p]) : '0;
      bus.eng_rgb_i[e*3*CB +: 3*CB] = has ? (3*CB)'(src_rgb[e][p]) : '0;
    end
    bus.pix_ready_i = ($urandom_range(99) < rdy_pct);
  endtask

  // One clock: drive, compare against the model at negedge, advance the model.
  task automatic cycle();
    int sz, e, p;
    bit pop, xfer, clip;
    logic [NE-1:0] exp_rdy;
    exp_t px;
    drive();
    @(negedge clk);
    sz = m_q.size();
    pop = (sz > 0) && bus.pix_ready_i;
    exp_rdy = '0;
    xfer = 1'b0;
    clip = 1'b0;
    e = m_grant;
    if (m_lock) begin
      p = src_pos[e];
      if (p < src_len[e]) clip = off_screen(src_x[e][p], src_y[e][p]);
      exp_rdy[e] = clip || (sz < DEPTH) || pop;
      xfer = bus.eng_valid_i[e] && exp_rdy[e];
    end
    check("eng_ready", 32'(bus.eng_ready_o), 32'(exp_rdy));
    check("pix_valid", 32'(bus.pix_valid_o), 32'(sz > 0));
    check("busy", 32'(bus.busy_o), 32'(m_lock || (sz > 0)));
    check("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_drop));
    if (sz > 0) begin
      check("x", 32'(bus.x_o), 32'(m_q[0].x));
      check("y", 32'(bus.y_o), 32'(m_q[0].y));
      check("rgb", 32'({bus.r_o, bus.g_o, bus.b_o}), 32'(m_q[0].rgb));
      check("eng_id", 32'(bus.eng_id_o), 32'(m_q[0].id));
    end
    if (pop) void'(m_q.pop_front());
    if (xfer) begin
      p = src_pos[e];
      if (clip) begin
        if (m_drop < 16'hFFFF) m_drop++;
      end else begin
        px.x = src_x[e][p]; px.y = src_y[e][p]; px.rgb = src_rgb[e][p]; px.id = e;
        m_q.push_back(px);
      end
      m_accepted++;
      if (src_last[e][p]) begin
        m_lock = 1'b0;
        m_last = e;
      end
      src_pos[e]++;
    end else if (!m_lock) begin
      for (int k = 1; k <= NE; k++) begin
        int idx = (m_last + k) % NE;
        if (!m_lock && bus.eng_valid_i[idx]) begin
          m_lock = 1'b1;
          m_grant = idx;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int left = budget;
    while ((pending() || (m_q.size() > 0) || m_lock) && (left > 0)) begin
      cycle();
      left--;
    end
    check({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_idle_valid"}, 32'(bus.pix_valid_o), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_valid"}, 32'(bus.pix_valid_o), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_eng_ready"}, 32'(bus.eng_ready_o), 32'd0);
    check({tag, "_xy"}, 32'({bus.x_o, bus.y_o}), 32'd0);
    check({tag, "_rgb"}, 32'({bus.r_o, bus.g_o, bus.b_o}), 32'd0);
    check({tag, "_eng_id"}, 32'(bus.eng_id_o), 32'd0);
    check({tag, "_drop"}, 32'(bus.drop_cnt_o), 32'd0);
  endtask

  task automatic pulse_reset();
    n_rst = 1'b1;
    bus.eng_valid_i = '0;
    bus.pix_ready_i = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    model_reset();
    clear_src();
  endtask

  initial begin
    int start;
    bus.eng_valid_i = '0;
    bus.eng_last_i  = '0;
    bus.eng_x_i     = '0;
    bus.eng_y_i     = '0;
    bus.eng_rgb_i   = '0;
    bus.pix_ready_i = 1'b0;
    valid_pct = 100;
    rdy_pct   = 100;
    m_accepted = 0;
    clear_src();
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");

    // Engine 1 draws a 3-pixel line.
    add_pix(1, 10, 5, 24'h112233, 1'b0);
    add_pix(1, 11, 5, 24'h445566, 1'b0);
    add_pix(1, 12, 5, 24'h778899, 1'b1);
    cycle();
    check("line_grant_ready", 32'(bus.eng_ready_o), 32'b0010);
    drain("line", 50);

    // Engines 0 and 2 compete with 2-pixel primitives.
    for (int j = 0; j < 2; j++) begin
      add_pix(0, 100 + 2*j, 20, 24'h0000A0 + j, 1'b0);
      add_pix(0, 101 + 2*j, 20, 24'h0000B0 + j, 1'b1);
      add_pix(2, 200 + 2*j, 40, 24'h00C000 + j, 1'b0);
      add_pix(2, 201 + 2*j, 40, 24'h00D000 + j, 1'b1);
    end
    drain("rr", 100);

    // Downstream stalled: engine 3 fills the FIFO and is held off.
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) add_pix(3, 300 + i, 60, 24'hE00000 + i, i == 5);
    repeat (8) cycle();
    check("stall_ready3", 32'(bus.eng_ready_o[3]), 32'd0);
    rdy_pct = 100;
    drain("stall", 50);

    // Full FIFO then sustained push+pop.
    rdy_pct = 0;
    for (int i = 0; i < 12; i++) add_pix(3, 400 + i, 70, 24'hF00000 + i, i == 11);
    repeat (6) cycle();
    rdy_pct = 100;
    drain("sustain", 60);

    // Reset in the middle of a primitive.
    for (int i = 0; i < 5; i++) add_pix(2, 500 + i, 80, 24'h123400 + i, i == 4);
    start = m_accepted;
    for (int i = 0; (i < 20) && (m_accepted < start + 2); i++) cycle();
    pulse_reset();
    check_reset_outputs("midrst");
    add_pix(0, 1, 2, 24'hAAAAAA, 1'b1);
    add_pix(3, 3, 4, 24'h555555, 1'b1);
    cycle();
    check("restart_grant0", 32'(bus.eng_ready_o), 32'b0001);
    drain("restart", 50);

    // Screen-edge pixels.
    add_pix(1, 639, 0, 24'h010203, 1'b0);
    add_pix(1, 640, 0, 24'h040506, 1'b0);
    add_pix(1, 0, 480, 24'h070809, 1'b1);
    drain("edge", 50);
`ifdef GPU_PIXEL_ARBITER_PIXEL_CLIP_EN
    check("clip_drop_cnt", 32'(bus.drop_cnt_o), 32'd2);
`endif

    // Randomized traffic: two rounds with different pressure.
    valid_pct = 70;
    rdy_pct   = 60;
    clear_src();
    for (int e = 0; e < NE; e++) for (int j = 0; j < 6; j++) add_rand_prim(e);
    drain("rand1", 3000);
    valid_pct = 100;
    rdy_pct   = 30;
    clear_src();
    for (int e = 0; e < NE; e++) for (int j = 0; j < 6; j++) add_rand_prim(e);
    drain("rand2", 3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
